// File: rtl/logic_reduce_pipe_if.sv
// Handshake bundle for logic_reduce_pipe: operand beat in, reduced bit out.
// The master side drives operands and out_ready; the slave side is the reduction pipe.
interface logic_reduce_pipe_if #(
    parameter int N_IN = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic [2:0]      in_op;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;
    logic            out_op_err;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_bit, out_op_err
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_bit, out_op_err
    );
endinterface

// File: rtl/logic_reduce_pipe.sv
// Pipelined N-input AND/OR/XOR (and inverted) reduction tree with valid/ready
// flow control and saturating result statistics.
module logic_reduce_pipe #(
    parameter int N_IN  = 16,
    parameter int RADIX = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    logic_reduce_pipe_if.slave bus,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } baseOpE;

    function automatic int stageWidth(input int k);
        int w;
        w = N_IN;
        for (int s = 0; s < k; s++) begin
            w = (w + RADIX - 1) / RADIX;
        end
        return w;
    endfunction

    function automatic int numStages();
        int w;
        int n;
        w = N_IN;
        n = 0;
        for (int s = 0; s < 32; s++) begin
            if (w > 1) begin
                w = (w + RADIX - 1) / RADIX;
                n++;
            end
        end
        return n;
    endfunction

    localparam int L        = numStages();
    localparam int MID      = (L > 1) ? L - 1 : 1;
    localparam int LAST_MID = (L > 1) ? L - 2 : 0;

    function automatic baseOpE baseOf(input logic [2:0] op);
        case (op)
            3'd1, 3'd4: baseOf = BASE_OR;
            3'd2, 3'd5: baseOf = BASE_XOR;
            default:    baseOf = BASE_AND;
        endcase
    endfunction

    // One tree level: group j folds inputs j*RADIX .. j*RADIX+RADIX-1, with
    // positions beyond the live width w contributing the op's identity value.
    function automatic logic [N_IN-1:0] reduceLevel(input logic [N_IN-1:0] v,
                                                    input int w,
                                                    input baseOpE base);
        logic [N_IN-1:0] res;
        logic [N_IN-1:0] sh;
        logic            acc;
        res = '0;
        for (int j = 0; j < N_IN; j++) begin
            acc = (base == BASE_AND);
            for (int i = 0; i < RADIX; i++) begin
                if (j * RADIX + i < w) begin
                    sh = v >> (j * RADIX + i);
                    case (base)
                        BASE_AND: acc = acc & sh[0];
                        BASE_OR:  acc = acc | sh[0];
                        default:  acc = acc ^ sh[0];
                    endcase
                end
            end
            res[j] = acc;
        end
        return res;
    endfunction

    logic [N_IN-1:0] midData_q [MID];
    logic [N_IN-1:0] midData_d [MID];
    logic [2:0]      midOp_q   [MID];
    logic            midValid_q [MID];
    logic            outValid_q;
    logic            outBit_q;
    logic            outErr_q;
    logic            finalBit_d;
    logic            finalErr_d;
    logic [CNT_W-1:0] onesCnt_q;
    logic [CNT_W-1:0] totalCnt_q;
    logic [N_IN-1:0] src;
    logic [2:0]      srcOp;
    logic [N_IN-1:0] lvl;
    logic            adv;
    logic            outXfer;

    assign adv     = !(outValid_q && !bus.out_ready);
    assign outXfer = outValid_q && bus.out_ready;

    // Stage s reduces stage s-1; inversion and illegal-op forcing happen only
    // when producing the final registered bit.
    always_comb begin
        for (int k = 0; k < MID; k++) begin
            midData_d[k] = '0;
        end
        finalBit_d = 1'b0;
        finalErr_d = 1'b0;
        src        = '0;
        srcOp      = '0;
        lvl        = '0;
        for (int s = 1; s <= L; s++) begin
            if (s == 1) begin
                src   = bus.in_data;
                srcOp = bus.in_op;
            end else begin
                src   = midData_q[(s >= 2) ? s - 2 : 0];
                srcOp = midOp_q[(s >= 2) ? s - 2 : 0];
            end
            lvl = reduceLevel(src, stageWidth(s - 1), baseOf(srcOp));
            if (s < L) begin
                midData_d[(s < L) ? s - 1 : 0] = lvl;
            end else begin
                finalBit_d = lvl[0];
                if (srcOp inside {3'd3, 3'd4, 3'd5}) begin
                    finalBit_d = ~lvl[0];
                end
                if (srcOp[2:1] == 2'b11) begin
                    finalBit_d = 1'b0;
                    finalErr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MID; k++) begin
                midValid_q[k] <= 1'b0;
            end
            outValid_q <= 1'b0;
            outBit_q   <= 1'b0;
            outErr_q   <= 1'b0;
            onesCnt_q  <= '0;
            totalCnt_q <= '0;
        end else begin
            if (adv) begin
                midValid_q[0] <= bus.in_valid;
                midData_q[0]  <= midData_d[0];
                midOp_q[0]    <= bus.in_op;
                for (int k = 1; k < MID; k++) begin
                    midValid_q[k] <= midValid_q[k-1];
                    midData_q[k]  <= midData_d[k];
                    midOp_q[k]    <= midOp_q[k-1];
                end
                outValid_q <= (L == 1) ? bus.in_valid : midValid_q[LAST_MID];
                outBit_q   <= finalBit_d;
                outErr_q   <= finalErr_d;
            end
            // Clear beats a same-cycle increment; both counters stick at all-ones.
            if (stat_clr) begin
                onesCnt_q  <= '0;
                totalCnt_q <= '0;
            end else if (outXfer) begin
                if (totalCnt_q != {CNT_W{1'b1}}) begin
                    totalCnt_q <= totalCnt_q + 1'b1;
                end
                if (outBit_q && (onesCnt_q != {CNT_W{1'b1}})) begin
                    onesCnt_q <= onesCnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = outValid_q;
    assign bus.out_bit    = outBit_q;
    assign bus.out_op_err = outErr_q;
    assign ones_cnt       = onesCnt_q;
    assign total_cnt      = totalCnt_q;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench for logic_reduce_pipe: a default 16/4/16 build and a
// 5/2/3 build exercising padding, 3-stage latency and counter saturation.
module tb_logic_reduce_pipe;

    typedef struct packed {
        logic err;
        logic bitv;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        statClrA = 1'b0;
    logic        statClrB = 1'b0;
    logic [15:0] onesCntA;
    logic [15:0] totalCntA;
    logic [2:0]  onesCntB;
    logic [2:0]  totalCntB;
    int          total = 0;
    int          bad = 0;
    int          waited;
    int          sumWait;
    expT         expA[$];
    expT         expB[$];
    expT         popA;
    expT         popB;

    always #5 clk = ~clk;

    logic_reduce_pipe_if #(.N_IN(16)) busA ();
    logic_reduce_pipe_if #(.N_IN(5))  busB ();

    logic_reduce_pipe #(.N_IN(16), .RADIX(4), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .bus(busA), .stat_clr(statClrA),
        .ones_cnt(onesCntA), .total_cnt(totalCntA)
    );

    logic_reduce_pipe #(.N_IN(5), .RADIX(2), .CNT_W(3)) dutB (
        .clk(clk), .rst(rst), .bus(busB), .stat_clr(statClrB),
        .ones_cnt(onesCntB), .total_cnt(totalCntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Flat reference reduction over the live bits; no tree structure involved.
    function automatic expT refModel(input logic [15:0] data, input int width, input logic [2:0] op);
        expT  r;
        logic acc;
        acc = (op == 3'd0 || op == 3'd3 || op >= 3'd6);
        for (int i = 0; i < width; i++) begin
            case (op)
                3'd1, 3'd4: acc = acc | data[i];
                3'd2, 3'd5: acc = acc ^ data[i];
                default:    acc = acc & data[i];
            endcase
        end
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) acc = ~acc;
        r.err  = (op >= 3'd6);
        r.bitv = (op >= 3'd6) ? 1'b0 : acc;
        return r;
    endfunction

    task automatic applyStimulus(input bit onB, input logic [15:0] data, input logic [2:0] op,
                                 output int waitCnt);
        logic rdy;
        if (onB) begin
            busB.in_valid = 1'b1;
            busB.in_data  = data[4:0];
            busB.in_op    = op;
        end else begin
            busA.in_valid = 1'b1;
            busA.in_data  = data;
            busA.in_op    = op;
        end
        for (waitCnt = 0; waitCnt < 64; waitCnt++) begin
            @(negedge clk);
            rdy = onB ? busB.in_ready : busA.in_ready;
            if (rdy) break;
        end
        if (waitCnt >= 64) begin
            checkOutput(onB ? "B_accept_timeout" : "A_accept_timeout", waitCnt, 0);
        end else if (onB) begin
            expB.push_back(refModel(data, 5, op));
        end else begin
            expA.push_back(refModel(data, 16, op));
        end
        @(posedge clk);
        #1;
        if (onB) busB.in_valid = 1'b0;
        else     busA.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input bit onB);
        int left;
        left = onB ? expB.size() : expA.size();
        for (int i = 0; i < 64 && left != 0; i++) begin
            @(posedge clk);
            #1;
            left = onB ? expB.size() : expA.size();
        end
        checkOutput(onB ? "B_drain" : "A_drain", left, 0);
    endtask

    task automatic pulseClear(input bit onB);
        if (onB) statClrB = 1'b1;
        else     statClrA = 1'b1;
        @(posedge clk);
        #1;
        statClrA = 1'b0;
        statClrB = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && busA.out_valid && busA.out_ready) begin
            if (expA.size() == 0) begin
                checkOutput("A_unexpected", 0, 1);
            end else begin
                popA = expA.pop_front();
                checkOutput("A_bit", busA.out_bit, popA.bitv);
                checkOutput("A_err", busA.out_op_err, popA.err);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && busB.out_valid && busB.out_ready) begin
            if (expB.size() == 0) begin
                checkOutput("B_unexpected", 0, 1);
            end else begin
                popB = expB.pop_front();
                checkOutput("B_bit", busB.out_bit, popB.bitv);
                checkOutput("B_err", busB.out_op_err, popB.err);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        busA.in_valid = 1'b0; busA.in_data = '0; busA.in_op = '0; busA.out_ready = 1'b1;
        busB.in_valid = 1'b0; busB.in_data = '0; busB.in_op = '0; busB.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_A_ovalid", busA.out_valid, 0);
        checkOutput("rst_A_obit", busA.out_bit, 0);
        checkOutput("rst_A_err", busA.out_op_err, 0);
        checkOutput("rst_A_ones", onesCntA, 0);
        checkOutput("rst_A_total", totalCntA, 0);
        checkOutput("rst_B_ovalid", busB.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_A_iready", busA.in_ready, 1);
        checkOutput("rst_B_iready", busB.in_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] single beat latency");
        applyStimulus(1'b0, 16'hFFFF, 3'd0, waited);
        @(negedge clk);
        checkOutput("A_lat_early", busA.out_valid, 0);
        @(negedge clk);
        checkOutput("A_lat_valid", busA.out_valid, 1);
        checkOutput("A_lat_bit", busA.out_bit, 1);
        @(posedge clk);
        #1;
        waitDrain(1'b0);
        @(negedge clk);
        checkOutput("A_cnt1_ones", onesCntA, 1);
        checkOutput("A_cnt1_total", totalCntA, 1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back mixed ops");
        pulseClear(1'b0);
        sumWait = 0;
        applyStimulus(1'b0, 16'hFFFF, 3'd0, waited); sumWait += waited;
        applyStimulus(1'b0, 16'hFFFE, 3'd0, waited); sumWait += waited;
        applyStimulus(1'b0, 16'h0001, 3'd1, waited); sumWait += waited;
        applyStimulus(1'b0, 16'h0003, 3'd2, waited); sumWait += waited;
        applyStimulus(1'b0, 16'h0003, 3'd5, waited); sumWait += waited;
        applyStimulus(1'b0, 16'h0000, 3'd3, waited); sumWait += waited;
        checkOutput("A_b2b_nowait", sumWait, 0);
        waitDrain(1'b0);
        @(negedge clk);
        checkOutput("A_b2b_ones", onesCntA, 4);
        checkOutput("A_b2b_total", totalCntA, 6);
        @(posedge clk);
        #1;

        $display("[TB] output stall");
        busA.out_ready = 1'b0;
        applyStimulus(1'b0, 16'h00FF, 3'd1, waited);
        applyStimulus(1'b0, 16'h0F0F, 3'd2, waited);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("A_stall_iready", busA.in_ready, 0);
            checkOutput("A_stall_ovalid", busA.out_valid, 1);
            checkOutput("A_stall_obit", busA.out_bit, expA[0].bitv);
            @(posedge clk);
            #1;
        end
        busA.out_ready = 1'b1;
        applyStimulus(1'b0, 16'h8000, 3'd4, waited);
        waitDrain(1'b0);

        $display("[TB] illegal ops");
        pulseClear(1'b0);
        applyStimulus(1'b0, 16'hFFFF, 3'd6, waited);
        applyStimulus(1'b0, 16'hFFFF, 3'd0, waited);
        applyStimulus(1'b0, 16'h0000, 3'd7, waited);
        waitDrain(1'b0);
        @(negedge clk);
        checkOutput("A_ill_ones", onesCntA, 1);
        checkOutput("A_ill_total", totalCntA, 3);
        @(posedge clk);
        #1;

        $display("[TB] random beats");
        for (int r = 0; r < 20; r++) begin
            applyStimulus(1'b0, 16'($urandom), 3'($urandom_range(0, 7)), waited);
        end
        waitDrain(1'b0);

        $display("[TB] narrow build latency and padding");
        applyStimulus(1'b1, 16'h001F, 3'd0, waited);
        @(negedge clk);
        checkOutput("B_lat_e1", busB.out_valid, 0);
        @(negedge clk);
        checkOutput("B_lat_e2", busB.out_valid, 0);
        @(negedge clk);
        checkOutput("B_lat_valid", busB.out_valid, 1);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'h0010, 3'd1, waited);
        applyStimulus(1'b1, 16'h0010, 3'd2, waited);
        applyStimulus(1'b1, 16'h001F, 3'd2, waited);
        applyStimulus(1'b1, 16'h001F, 3'd5, waited);
        applyStimulus(1'b1, 16'h0006, 3'd3, waited);
        waitDrain(1'b1);

        $display("[TB] counter saturation");
        pulseClear(1'b1);
        for (int r = 0; r < 9; r++) begin
            applyStimulus(1'b1, 16'h001F, 3'd0, waited);
        end
        waitDrain(1'b1);
        @(negedge clk);
        checkOutput("B_sat_ones", onesCntB, 7);
        checkOutput("B_sat_total", totalCntB, 7);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 16'h001F, 3'd0, waited);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("B_clr_ovalid", busB.out_valid, 1);
        statClrB = 1'b1;
        @(posedge clk);
        #1;
        statClrB = 1'b0;
        @(negedge clk);
        checkOutput("B_clr_ones", onesCntB, 0);
        checkOutput("B_clr_total", totalCntB, 0);
        @(posedge clk);
        #1;

        $display("[TB] reset with beats in flight");
        applyStimulus(1'b1, 16'h001F, 3'd0, waited);
        applyStimulus(1'b1, 16'h001F, 3'd0, waited);
        rst = 1'b1;
        expA.delete();
        expB.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("B_rst_ovalid", busB.out_valid, 0);
        end
        checkOutput("A_rst_total", totalCntA, 0);
        checkOutput("A_rst_ones", onesCntA, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_reduce_pipe.md
# logic_reduce_pipe

Parametrised, pipelined N-input reduction gate: the registered, multi-operation successor to the fixed 4-input combinational AND. It accepts an N_IN-bit operand with a per-beat operation code, reduces it through a radix-RADIX register tree under a valid/ready handshake, and keeps saturating result statistics. It sits between operand producers and any consumer needing a registered single-bit reduce with flow control.

## Interface
- N_IN, 16, operand width (number of gate inputs), ≥2
- RADIX, 4, inputs combined per tree node per stage, ≥2
- CNT_W, 16, width of statistics counters
- Derived: L = ceil(log_RADIX(N_IN)) pipeline stages (L=2 at defaults)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept beat this cycle
- in_data  in  N_IN  operand bits
- in_op  in  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 illegal
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_bit  out  1  reduction result
- out_op_err  out  1  result belongs to an illegal-op beat (qualified by out_valid)
- stat_clr  in  1  synchronous clear of counters
- ones_cnt  out  CNT_W  transferred results with out_bit=1
- total_cnt  out  CNT_W  transferred results

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Tree: stage k reduces groups of RADIX values from stage k-1 with base op (AND for 0/3/6/7, OR for 1/4, XOR for 2/5). Partial groups padded with identity: 1 for AND, 0 for OR/XOR.
- Op code travels with its beat through every stage; beats with different ops may occupy the pipe simultaneously without interaction.
- Inversion (ops 3,4,5) applied at final stage only.
- Illegal op 6/7: out_bit forced 0, out_op_err=1 for that beat only; still handshaken and counted in total_cnt (never in ones_cnt).
- Flow control: global stall. adv = !(out_valid && !out_ready); in_ready = adv. When adv=1 every stage register loads from its predecessor (valid bit included); when 0 all stages hold.
- Bubbles: stage valid bits propagate; invalid stages carry don't-care data but never produce out_valid.
- Counters: on output transfer total_cnt+1; also ones_cnt+1 if out_bit=1. Both saturate at 2^CNT_W−1 (no wrap). stat_clr zeroes both and wins over a same-cycle increment.

## Timing
- Reset values: all stage valids 0, out_valid 0, out_bit 0, out_op_err 0, ones_cnt 0, total_cnt 0. in_ready 1 in the cycle after reset deasserts (out_valid=0 ⇒ adv=1).
- Reset mid-operation: all in-flight beats discarded, no output transfer completes in the reset cycle, counters cleared.
- Latency: beat accepted at edge t appears with out_valid=1 after edge t+L−1 (visible L cycles after acceptance cycle) with no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid && !out_ready ⇒ in_ready=0 same cycle (combinational from out_ready); out_bit/out_op_err/out_valid stable until transfer.
- out_bit, out_op_err, out_valid are registered; no combinational path from in_* to out_*.
- N_IN ≤ RADIX ⇒ L=1.

## Test plan
- Reset, then in_data=16'hFFFF op=0 one beat, out_ready=1 -> out_valid=1 with out_bit=1 exactly 2 cycles after acceptance; total_cnt=1, ones_cnt=1.
- Back-to-back beats FFFF/AND, FFFE/AND, 0001/OR, 0003/XOR, 0003/XNOR, 0000/NAND -> out_bit sequence 1,0,1,0,1,1 on consecutive cycles, ones_cnt=4, total_cnt=6.
- out_ready held 0 for 5 cycles with pipe full -> in_ready=0, out_bit/out_valid held, no beat lost or duplicated; release yields original order.
- op=6 with in_data=FFFF -> out_bit=0, out_op_err=1, total_cnt+1, ones_cnt unchanged; next legal beat out_op_err=0.
- N_IN=5, RADIX=2 build (L=3): 5'b11111 AND -> 1, 5'b10000 OR -> 1, 5'b10000 XOR -> 1, 5'b11111 XOR -> 1 (padding identity check), latency 3.
- CNT_W=3: 9 transfers of 1 -> both counters stick at 7; stat_clr during a transfer -> both 0 next cycle; rst asserted with 2 beats in flight -> no out_valid afterwards.
